// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes ALU operands, applies write-back forwarding and
// presents them through a registered main+skid buffer with valid/ready on both sides.
module alu_issue_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rs1,
  output logic [31:0] rs2,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  dest,
  output logic        illegal
);
  if (DEPTH != 2) begin : g_depth
    $error("alu_issue_stage supports DEPTH=2 only");
  end
  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  dst;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        rb_reg;
    logic        ill;
  } ent_t;
  // Register-sourced operands track later write-backs; index 0 and immediates never change.
  function automatic ent_t fwd(input ent_t e, input logic we, input logic [4:0] rd, input logic [31:0] d);
    fwd = e;
    if (we && e.ra != 5'd0 && e.ra == rd) fwd.a = d;
    if (we && e.rb_reg && e.rb != 5'd0 && e.rb == rd) fwd.b = d;
  endfunction
  ent_t m, s, raw, nw;
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  logic r_type, fn_ok, op_ok, sext, shamt, imm_sel, issue, acc, unused_bits;
  logic [31:0] imm;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign unused_bits = ^instr[10:6];
  assign r_type = op == 6'd0;
  assign fn_ok = fn inside {[6'd8:6'd13], [6'd16:6'd20], [6'd25:6'd27], 6'd40, 6'd48, 6'd49};
  assign op_ok = op inside {6'd8, 6'd9, 6'd16, 6'd17, 6'd18, 6'd24, 6'd25, 6'd26, 6'd48};
  assign sext = op == 6'd8 || op == 6'd9;
  assign shamt = op inside {6'd24, 6'd25, 6'd26};
  assign imm_sel = !r_type && op_ok;
  assign imm = sext ? {{16{instr[15]}}, instr[15:0]} : shamt ? {27'b0, instr[4:0]} : {16'b0, instr[15:0]};
  // Illegal decodes fall back to R-type operand handling.
  always_comb begin
    raw = ent_t'(0);
    raw.v = 1'b1;
    raw.a = rs == 5'd0 ? 32'd0 : rs_data;
    raw.b = imm_sel ? imm : rt == 5'd0 ? 32'd0 : rt_data;
    raw.op = op;
    raw.fn = fn;
    raw.dst = imm_sel ? rt : rd;
    raw.ra = rs;
    raw.rb = rt;
    raw.rb_reg = !imm_sel;
    raw.ill = r_type ? !fn_ok : !op_ok;
  end
  assign nw = fwd(raw, wb_we, wb_rd, wb_data);
  assign issue = m.v & out_ready;
  assign acc = in_valid & ~s.v;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= ent_t'(0);
      s <= ent_t'(0);
    end else if (flush) begin
      m.v <= 1'b0;
      s.v <= 1'b0;
    end else if (!m.v || issue) begin
      m <= s.v ? fwd(s, wb_we, wb_rd, wb_data) : acc ? nw : ent_t'(0);
      s.v <= 1'b0;
    end else begin
      m <= fwd(m, wb_we, wb_rd, wb_data);
      s <= s.v ? fwd(s, wb_we, wb_rd, wb_data) : acc ? nw : s;
    end
  end
  assign in_ready = ~s.v;
  assign out_valid = m.v;
  assign rs1 = m.a;
  assign rs2 = m.b;
  assign opcode = m.op;
  assign funct = m.fn;
  assign dest = m.dst;
  assign illegal = m.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench; a queue models the buffered instructions
// and a negedge monitor compares every issue against it.
module tb_alu_issue_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, wb_we = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, rs_data = '0, rt_data = '0, wb_data = '0;
  logic [4:0] wb_rd = '0;
  logic in_ready, out_valid, illegal;
  logic [31:0] rs1, rs2;
  logic [5:0] opcode, funct;
  logic [4:0] dest;
  int errors = 0, checks = 0;
  typedef struct {
    logic [31:0] a, b;
    logic [5:0]  op, fn;
    logic [4:0]  dst, ra, rb;
    logic        breg, ill;
  } exp_t;
  exp_t q[$];
  alu_issue_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .rs1(rs1), .rs2(rs2),
    .opcode(opcode), .funct(funct), .dest(dest), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask
  function automatic logic legal_fn(input logic [5:0] f);
    logic [5:0] lst [17] = '{8, 9, 10, 11, 12, 13, 16, 17, 18, 19, 20, 25, 26, 27, 40, 48, 49};
    legal_fn = 1'b0;
    foreach (lst[k]) if (lst[k] == f) legal_fn = 1'b1;
  endfunction
  function automatic exp_t upd(input exp_t e, input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    upd = e;
    if (we && wrd != 0 && wrd == e.ra) upd.a = wd;
    if (we && wrd != 0 && e.breg && wrd == e.rb) upd.b = wd;
  endfunction
  function automatic exp_t mk(input logic [31:0] i, input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    exp_t e;
    logic [15:0] im;
    im = i[15:0];
    e.op = i[31:26];
    e.fn = i[5:0];
    e.ra = i[25:21];
    e.rb = i[20:16];
    e.ill = 1'b0;
    e.breg = 1'b0;
    e.b = 32'd0;
    case (e.op)
      6'd0: begin e.breg = 1'b1; e.ill = !legal_fn(e.fn); end
      6'd8, 6'd9: e.b = 32'(signed'(im));
      6'd16, 6'd17, 6'd18, 6'd48: e.b = 32'(im);
      6'd24, 6'd25, 6'd26: e.b = 32'(im % 32);
      default: begin e.breg = 1'b1; e.ill = 1'b1; end
    endcase
    if (e.breg) e.b = e.rb == 0 ? 32'd0 : rtd;
    e.dst = e.breg ? i[15:11] : i[20:16];
    e.a = e.ra == 0 ? 32'd0 : rsd;
    mk = upd(e, we, wrd, wd);
  endfunction
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready && q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("rs1", rs1, e.a);
          chk("rs2", rs2, e.b);
          chk("opcode", 32'(opcode), 32'(e.op));
          chk("funct", 32'(funct), 32'(e.fn));
          chk("dest", 32'(dest), 32'(e.dst));
          chk("illegal", 32'(illegal), 32'(e.ill));
        end
        foreach (q[k]) q[k] = upd(q[k], wb_we, wb_rd, wb_data);
        if (in_valid && in_ready) q.push_back(mk(instr, rs_data, rt_data, wb_we, wb_rd, wb_data));
      end
    end
  end
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd,
                     input logic we, input logic [4:0] wrd, input logic [31:0] wd, input logic ordy, input logic fl);
    in_valid = iv; instr = ins; rs_data = rsd; rt_data = rtd;
    wb_we = we; wb_rd = wrd; wb_data = wd; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] r_i(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    r_i = {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
    i_i = {op, rs, rt, im};
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [5:0] ops [14] = '{0, 0, 0, 8, 9, 16, 17, 18, 24, 25, 26, 48, 63, 5};
    logic [5:0] fns [8] = '{8, 13, 16, 20, 27, 40, 49, 63};
    logic [5:0] f;
    f = $urandom_range(0, 3) == 0 ? 6'($urandom) : fns[$urandom_range(0, 7)];
    rnd_instr = {ops[$urandom_range(0, 13)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom), f};
  endfunction
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset rs1", rs1, 0);
    chk("reset rs2", rs2, 0);
    chk("reset opcode", 32'(opcode), 0);
    chk("reset funct", 32'(funct), 0);
    chk("reset dest", 32'(dest), 0);
    chk("reset illegal", 32'(illegal), 0);
    cyc(1, r_i(6'd8, 1, 2, 3), 5, 7, 0, 0, 0, 1, 0);
    cyc(1, i_i(6'd8, 1, 4, 16'hFFFC), 1, 2, 0, 0, 0, 1, 0);
    cyc(1, i_i(6'd17, 1, 4, 16'hFFFC), 1, 2, 0, 0, 0, 1, 0);
    cyc(1, i_i(6'd26, 1, 4, 16'h0023), 1, 2, 0, 0, 0, 1, 0);
    cyc(1, i_i(6'd48, 0, 9, 16'h1234), 1, 2, 0, 0, 0, 1, 0);
    cyc(1, r_i(6'd9, 4, 5, 6), 11, 12, 1, 4, 32'hDEADBEEF, 1, 0);
    cyc(1, r_i(6'd9, 0, 5, 6), 11, 12, 1, 0, 32'hCAFEF00D, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, r_i(6'd10, 2, 6, 1), 21, 22, 0, 0, 0, 0, 0);
    cyc(1, r_i(6'd11, 3, 6, 2), 31, 32, 0, 0, 0, 0, 0);
    cyc(1, r_i(6'd12, 2, 6, 3), 41, 42, 1, 6, 32'h600D6666, 0, 0);
    cyc(1, r_i(6'd13, 2, 7, 4), 51, 52, 0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, r_i(6'd8, 1, 1, 1), 1, 1, 0, 0, 0, 0, 0);
    cyc(1, r_i(6'd8, 2, 2, 2), 2, 2, 0, 0, 0, 0, 0);
    cyc(1, r_i(6'd8, 3, 3, 3), 3, 3, 0, 0, 0, 0, 1);
    cyc(1, r_i(6'd8, 4, 4, 4), 4, 4, 0, 0, 0, 1, 0);
    cyc(1, r_i(6'd63, 1, 2, 3), 5, 6, 0, 0, 0, 1, 0);
    cyc(1, i_i(6'd63, 1, 2, 16'h0808), 5, 6, 0, 0, 0, 1, 0);
    cyc(1, r_i(6'd49, 1, 2, 3), 5, 6, 0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 0);
        chk("async rst in_ready", 32'(in_ready), 1);
        chk("async rst rs1", rs1, 0);
        @(posedge clk);
        #1 rst = 1'b0;
      end
      cyc($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom, 1'($urandom),
          5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    chk("drain empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
